// File: rtl/cpu_ctl_pkg.sv
// cpu_ctl_pkg: state codes, opcodes and control-field encodings for the multicycle controller
package cpu_ctl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_EXEC_R = 4'd3;
    localparam state_t S_WB_R   = 4'd4;
    localparam state_t S_EXEC_I = 4'd5;
    localparam state_t S_WB_I   = 4'd6;
    localparam state_t S_ADDR   = 4'd7;
    localparam state_t S_MEM_RD = 4'd8;
    localparam state_t S_WB_MEM = 4'd9;
    localparam state_t S_MEM_WR = 4'd10;
    localparam state_t S_BRANCH = 4'd11;
    localparam state_t S_JUMP   = 4'd12;
    localparam state_t S_ERR    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that hold a RAM request open and are therefore watched by the wait timer
    function automatic logic is_mem_state(input state_t s);
        return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
    endfunction

endpackage

// File: rtl/cpu_ctl_wait_timer.sv
// cpu_ctl_wait_timer: counts consecutive memory wait cycles and flags the one that reaches MEM_WAIT_MAX
module cpu_ctl_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = MEM_WAIT_MAX < 2 ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [W-1:0] count;

    // Wait-cycle counter; cleared whenever no request is pending or the request completes
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + W'(1);

    // The wait cycle that would make the count equal the limit is the expiring one;
    // a ready cycle never increments, so ready at that point always wins
    generate
        if (MEM_WAIT_MAX == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = inc && count == W'(MEM_WAIT_MAX - 1);
        end
    endgenerate

endmodule

// File: rtl/cpu_multicycle_ctl.sv
// cpu_multicycle_ctl: multicycle CPU control FSM with memory handshake, wait timeout and retire counter
// Optional illegal-opcode trap: define CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN (otherwise unsupported opcodes are NOPs)
module cpu_multicycle_ctl
    import cpu_ctl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          Opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                mem_err,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

`ifdef CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN
    localparam state_t UNSUP_NEXT = S_ERR;
`else
    localparam state_t UNSUP_NEXT = S_FETCH;
`endif

    state_t state, next;
    logic   mem_wait, expire;

    assign mem_wait = is_mem_state(state);

    cpu_ctl_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk    (clk),
        .rst    (reset),
        .clr    (!mem_wait || mem_ready),
        .inc    (mem_wait && !mem_ready),
        .expire (expire)
    );

    // Next-state selection; memory states wait on mem_ready and fall into ERR on timeout
    always_comb begin
        next = state;
        case (state)
            S_IDLE:   next = S_FETCH;
            S_FETCH:  next = mem_ready ? S_DECODE : expire ? S_ERR : S_FETCH;
            S_DECODE: next = Opcode == OP_RTYPE ? S_EXEC_R :
                             Opcode == OP_ADDI  ? S_EXEC_I :
                             (Opcode == OP_LW || Opcode == OP_SW) ? S_ADDR :
                             Opcode == OP_BEQ   ? S_BRANCH :
                             Opcode == OP_J     ? S_JUMP : UNSUP_NEXT;
            S_EXEC_R: next = S_WB_R;
            S_WB_R:   next = S_FETCH;
            S_EXEC_I: next = S_WB_I;
            S_WB_I:   next = S_FETCH;
            S_ADDR:   next = Opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: next = mem_ready ? S_WB_MEM : expire ? S_ERR : S_MEM_RD;
            S_WB_MEM: next = S_FETCH;
            S_MEM_WR: next = mem_ready ? S_FETCH : expire ? S_ERR : S_MEM_WR;
            S_BRANCH: next = S_FETCH;
            S_JUMP:   next = S_FETCH;
            S_ERR:    next = S_ERR;
            default:  next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= S_IDLE;
        else
            state <= next;

    // Sticky timeout flag
    always_ff @(posedge clk or posedge reset)
        if (reset)
            mem_err <= 1'b0;
        else if (expire)
            mem_err <= 1'b1;

`ifdef CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN
    // Sticky illegal flag: the only DECODE exit into ERR is an unsupported opcode
    always_ff @(posedge clk or posedge reset)
        if (reset)
            illegal <= 1'b0;
        else if (state == S_DECODE && next == S_ERR)
            illegal <= 1'b1;
`else
    assign illegal = 1'b0;
`endif

    // An instruction retires on every return to FETCH except the initial one out of IDLE
    always_ff @(posedge clk or posedge reset)
        if (reset)
            retired <= '0;
        else if (next == S_FETCH && state != S_FETCH && state != S_IDLE)
            retired <= retired + RETIRE_W'(1);

    // Moore control decode; only the FETCH strobes and the BRANCH PCWrite look at inputs
    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PC_SEQ;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_EXEC_R: ALUOp = ALU_FUNCT;
            S_WB_R: begin
                ALUOp    = ALU_FUNCT;
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_EXEC_I, S_ADDR: ALUSrc = 1'b1;
            S_WB_I: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_RD: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                ALUOp   = ALU_SUB;
                PCWrite = Zero;
                PCSrc   = PC_BRANCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_multicycle_ctl.sv
// tb_cpu_multicycle_ctl: randomized instruction streams checked against a per-instruction cycle-trace model
module tb_cpu_multicycle_ctl;

    localparam logic [5:0] R_T = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

    logic        clk = 1'b0;
    logic        reset, Zero, mem_ready;
    logic [5:0]  Opcode;
    logic        RegDst, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, IorD, IRWrite, PCWrite;
    logic        mem_err, illegal;
    logic [1:0]  ALUOp, PCSrc;
    logic [31:0] retired;
    logic [14:0] obs;

    typedef struct {
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [14:0] exp;
        int          ret;
    } cyc_t;

    cyc_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ret_model = 0;

    always #5 clk = ~clk;

    cpu_multicycle_ctl dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .mem_err   (mem_err),
        .illegal   (illegal),
        .retired   (retired)
    );

    assign obs = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUOp,
                  ALUSrc, RegWrite, RegDst, MemtoReg, mem_err, illegal};

    // Expected control word for one cycle (flags zero)
    function automatic logic [14:0] ov(input logic mr, mw, iod, irw, pcw, input logic [1:0] pcs, aop,
                                       input logic asrc, rw, rd, m2r);
        return {mr, mw, iod, irw, pcw, pcs, aop, asrc, rw, rd, m2r, 2'b00};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rdy, z, input logic [5:0] op, input logic [14:0] e);
        cyc_t c;
        c.rdy = rdy;
        c.z   = z;
        c.op  = op;
        c.exp = e;
        c.ret = ret_model;
        q.push_back(c);
    endtask

    task automatic check(input string tag, input logic [14:0] e, input int r);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s controls observed=%b expected=%b", tag, obs, e);
        end
        vectors++;
        assert (retired === 32'(r)) else begin
            miscompares++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, r);
        end
    endtask

    // Expected cycle trace of one instruction: fl fetch waits, ml data-memory waits
    task automatic plan(input logic [5:0] op, input int fl, input int ml, input logic z);
        for (int i = 0; i < fl; i++) push(1'b0, rb(), op, ov(1,0,0,0,0,2'b00,2'b00,0,0,0,0));
        push(1'b1, rb(), op, ov(1,0,0,1,1,2'b00,2'b00,0,0,0,0));
        push(rb(), rb(), op, 15'd0);
        case (op)
            R_T: begin
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b10,0,0,0,0));
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b10,0,1,1,0));
            end
            ADDI: begin
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b00,1,0,0,0));
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b00,1,1,0,0));
            end
            LW: begin
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b00,1,0,0,0));
                for (int i = 0; i < ml; i++) push(1'b0, rb(), op, ov(1,0,1,0,0,2'b00,2'b00,1,0,0,0));
                push(1'b1, rb(), op, ov(1,0,1,0,0,2'b00,2'b00,1,0,0,0));
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b00,1,1,0,1));
            end
            SW: begin
                push(rb(), rb(), op, ov(0,0,0,0,0,2'b00,2'b00,1,0,0,0));
                for (int i = 0; i < ml; i++) push(1'b0, rb(), op, ov(0,1,1,0,0,2'b00,2'b00,1,0,0,0));
                push(1'b1, rb(), op, ov(0,1,1,0,0,2'b00,2'b00,1,0,0,0));
            end
            BEQ: push(rb(), z, op, ov(0,0,0,0,z,2'b01,2'b01,0,0,0,0));
            JMP: push(rb(), rb(), op, ov(0,0,0,0,1,2'b10,2'b00,0,0,0,0));
            default: ;
        endcase
        ret_model++;
    endtask

    // Apply queued cycles until only `left` remain; entered and left #1 after a rising edge
    task automatic run(input int left);
        while (q.size() > left) begin
            cyc_t c = q.pop_front();
            mem_ready = c.rdy;
            Zero      = c.z;
            Opcode    = c.op;
            @(negedge clk);
            check($sformatf("seq op=%b", c.op), c.exp, c.ret);
            @(posedge clk);
            #1;
        end
    endtask

    // Release reset, check the IDLE cycle, and land #1 into the first FETCH
    task automatic release_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check(tag, 15'd0, 0);
        @(posedge clk);
        #1;
        ret_model = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops[7];
        ops = '{R_T, ADDI, LW, SW, BEQ, JMP, BAD};
        reset = 1'b1;
        mem_ready = 1'b0;
        Zero = 1'b0;
        Opcode = 6'd0;
        @(negedge clk);
        check("reset", 15'd0, 0);
        release_reset("idle");
        plan(R_T, 0, 0, 0);
        plan(LW, 0, 3, 0);
        plan(BEQ, 0, 0, 1);
        plan(BEQ, 0, 0, 0);
        plan(JMP, 1, 0, 0);
        plan(ADDI, 2, 0, 0);
        plan(SW, 2, 2, 0);
        plan(R_T, 14, 0, 0);
        plan(LW, 0, 14, 0);
        plan(SW, 3, 14, 0);
`ifndef CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN
        plan(BAD, 0, 0, 0);
`endif
        repeat (40) begin
`ifdef CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN
            plan(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(0, 4), rb());
`else
            plan(ops[$urandom_range(0, 6)], $urandom_range(0, 4), $urandom_range(0, 4), rb());
`endif
        end
        run(0);

        plan(SW, 0, 10, 0);
        run(5);
        q.delete();
        mem_ready = 1'b0;
        @(negedge clk);
        check("mem_wr_pre_reset", ov(0,1,1,0,0,2'b00,2'b00,1,0,0,0), ret_model - 1);
        #1 reset = 1'b1;
        #1 check("mid_access_reset", 15'd0, 0);
        release_reset("idle_after_mid_reset");
        plan(ADDI, 0, 0, 0);
        run(0);
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        #1 check("reset_in_fetch", 15'd0, 0);
        release_reset("idle_before_timeout");

        for (int i = 0; i < 15; i++) push(1'b0, rb(), R_T, ov(1,0,0,0,0,2'b00,2'b00,0,0,0,0));
        for (int i = 0; i < 4; i++) push(rb(), rb(), R_T, 15'b10);
        run(0);
        reset = 1'b1;
        #1 check("reset_clears_err", 15'd0, 0);
        release_reset("idle_before_illegal");

        plan(BAD, 0, 0, 0);
`ifdef CPU_MULTICYCLE_CTL_ILLEGAL_TRAP_EN
        ret_model--;
        for (int i = 0; i < 3; i++) push(rb(), rb(), BAD, 15'b01);
`else
        plan(R_T, 0, 0, 0);
`endif
        run(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
